// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - scan codes, prefixes, move bit indices and rx state type
package ps2_pkg;

   localparam logic [7:0] SC_W     = 8'h1D;
   localparam logic [7:0] SC_S     = 8'h1B;
   localparam logic [7:0] SC_A     = 8'h1C;
   localparam logic [7:0] SC_D     = 8'h23;
   localparam logic [7:0] SC_SPACE = 8'h29;
   localparam logic [7:0] SC_ENTER = 8'h5A;
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_DOWN  = 8'h72;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_RIGHT = 8'h74;

   localparam logic [7:0] PFX_EXT = 8'hE0;
   localparam logic [7:0] PFX_BRK = 8'hF0;

   localparam int MV_LEFT  = 3;
   localparam int MV_RIGHT = 2;
   localparam int MV_UP    = 1;
   localparam int MV_DOWN  = 0;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } rx_state_e;

endpackage

// File: rtl/ps2_player_input_if.sv
// rtl/ps2_player_input_if.sv - player control and received-byte outputs of the PS/2 input stage
interface ps2_player_input_if;

   logic [3:0] player_1_move_o;
   logic [3:0] player_2_move_o;
   logic       player_1_shoot_o;
   logic       player_2_shoot_o;
   logic [7:0] rx_byte_o;
   logic       rx_valid_o;
   logic       rx_error_o;

   modport master (
      output player_1_move_o, player_2_move_o, player_1_shoot_o, player_2_shoot_o,
      output rx_byte_o, rx_valid_o, rx_error_o
   );

   modport slave (
      input player_1_move_o, player_2_move_o, player_1_shoot_o, player_2_shoot_o,
      input rx_byte_o, rx_valid_o, rx_error_o
   );

endinterface

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 line synchroniser, frame receiver FSM and mid-frame timeout
module ps2_rx
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic       clk_i,
   input  logic       reset_ni,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic [7:0] rx_byte_o,
   output logic       rx_valid_o,
   output logic       rx_error_o
);

   localparam int             CW      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] data_sync;
   logic                   clk_prev;
   logic                   fall_edge;
   logic                   data_bit;

   rx_state_e   state, next_state;
   logic [7:0]  shreg;
   logic [2:0]  bit_cnt;
   logic        par_bit;
   logic [CW-1:0] to_cnt;
   logic        timeout_hit;
   logic        frame_ok;
   logic        frame_bad;

   // Lines idle high, so the chain resets to 1 to avoid a spurious edge on release
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         clk_sync  <= '1;
         data_sync <= '1;
         clk_prev  <= 1'b1;
      end else begin
         clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk_i};
         data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data_i};
         clk_prev  <= clk_sync[SYNC_STAGES-1];
      end
   end

   assign fall_edge   = clk_prev & ~clk_sync[SYNC_STAGES-1];
   assign data_bit    = data_sync[SYNC_STAGES-1];
   assign timeout_hit = (state != RX_IDLE) && (to_cnt == TO_LAST) && !fall_edge;

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) state <= RX_IDLE;
      else           state <= next_state;
   end

   always_comb begin
      next_state = state;
      if (timeout_hit) begin
         next_state = RX_IDLE;
      end else if (fall_edge) begin
         case (state)
            RX_IDLE:   if (!data_bit) next_state = RX_DATA;
            RX_DATA:   if (bit_cnt == 3'd7) next_state = RX_PARITY;
            RX_PARITY: next_state = RX_STOP;
            RX_STOP:   next_state = RX_IDLE;
            default:   next_state = RX_IDLE;
         endcase
      end
   end

   always_comb begin
      frame_ok  = 1'b0;
      frame_bad = 1'b0;
      if (state == RX_STOP && fall_edge) begin
         if (data_bit && (^{shreg, par_bit})) frame_ok  = 1'b1;
         else                                 frame_bad = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         shreg      <= '0;
         bit_cnt    <= '0;
         par_bit    <= 1'b0;
         to_cnt     <= '0;
         rx_byte_o  <= '0;
         rx_valid_o <= 1'b0;
         rx_error_o <= 1'b0;
      end else begin
         if (fall_edge) begin
            case (state)
               RX_IDLE:   bit_cnt <= '0;
               RX_DATA: begin
                  shreg   <= {data_bit, shreg[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
               end
               RX_PARITY: par_bit <= data_bit;
               default:   ;
            endcase
         end

         // Saturating so a stuck line reports exactly one timeout
         if (fall_edge || state == RX_IDLE) to_cnt <= '0;
         else if (to_cnt != TO_LAST)        to_cnt <= to_cnt + 1'b1;

         rx_valid_o <= frame_ok;
         rx_error_o <= frame_bad | timeout_hit;
         if (frame_ok) rx_byte_o <= shreg;
      end
   end

endmodule

// File: rtl/ps2_player_input.sv
// rtl/ps2_player_input.sv - PS/2 set-2 decoder holding both players' move and fire keys
module ps2_player_input
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic             clk_i,
   input  logic             reset_ni,
   input  logic             ps2_clk_i,
   input  logic             ps2_data_i,
   ps2_player_input_if.master bus
);

   logic [7:0] rx_byte;
   logic       rx_valid;
   logic       rx_error;

   logic       ext, brk;
   logic [3:0] p1_move, p2_move;
   logic       p1_shoot, p2_shoot;

   ps2_rx #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
   ) u_rx (
      .clk_i      (clk_i),
      .reset_ni   (reset_ni),
      .ps2_clk_i  (ps2_clk_i),
      .ps2_data_i (ps2_data_i),
      .rx_byte_o  (rx_byte),
      .rx_valid_o (rx_valid),
      .rx_error_o (rx_error)
   );

   // Any receive error drops pending prefixes so they cannot attach to a later code
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         ext      <= 1'b0;
         brk      <= 1'b0;
         p1_move  <= '0;
         p2_move  <= '0;
         p1_shoot <= 1'b0;
         p2_shoot <= 1'b0;
      end else if (rx_error) begin
         ext <= 1'b0;
         brk <= 1'b0;
      end else if (rx_valid) begin
         if (rx_byte == PFX_EXT) begin
            ext <= 1'b1;
         end else if (rx_byte == PFX_BRK) begin
            brk <= 1'b1;
         end else begin
            ext <= 1'b0;
            brk <= 1'b0;
            if (!ext) begin
               case (rx_byte)
                  SC_W:     p1_move[MV_UP]    <= ~brk;
                  SC_S:     p1_move[MV_DOWN]  <= ~brk;
                  SC_A:     p1_move[MV_LEFT]  <= ~brk;
                  SC_D:     p1_move[MV_RIGHT] <= ~brk;
                  SC_SPACE: p1_shoot          <= ~brk;
                  SC_ENTER: p2_shoot          <= ~brk;
                  default:  ;
               endcase
            end else begin
               case (rx_byte)
                  SC_UP:    p2_move[MV_UP]    <= ~brk;
                  SC_DOWN:  p2_move[MV_DOWN]  <= ~brk;
                  SC_LEFT:  p2_move[MV_LEFT]  <= ~brk;
                  SC_RIGHT: p2_move[MV_RIGHT] <= ~brk;
                  SC_ENTER: p2_shoot          <= ~brk;
                  default:  ;
               endcase
            end
         end
      end
   end

   assign bus.player_1_move_o  = p1_move;
   assign bus.player_2_move_o  = p2_move;
   assign bus.player_1_shoot_o = p1_shoot;
   assign bus.player_2_shoot_o = p2_shoot;
   assign bus.rx_byte_o        = rx_byte;
   assign bus.rx_valid_o       = rx_valid;
   assign bus.rx_error_o       = rx_error;

endmodule
